data_mem_responder: RTL

Multi-cycle data-memory responder: the memory-side end of the Mem_En/Mem_Wr interface driven by CPU control for LW/SW. It accepts one request at a time, holds the pipeline via busy, commits writes or reads after a fixed latency, and signals completion with a one-cycle data_valid pulse. It sits between the MEM stage and the data array and replaces the single-cycle data memory.

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory that sits behind the MEM stage. It takes one LW/SW
// request at a time, stalls the pipeline with busy while the request is in
// flight, commits the access a fixed LAT cycles after accept and pulses
// data_valid for one cycle with the read data (or the echoed store data).
//
// Parameters
//   AW   word-address width; the array holds 2**AW 16-bit words
//   LAT  request-to-response latency in cycles, 1..15
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   mem_en      request strobe
//   mem_wr      1 = store, 0 = load; only meaningful with mem_en
//   addr        byte address; word index is addr[AW:1]
//   wdata       store data, captured at accept
//   rdata       load data / echoed store data, valid while data_valid=1
//   data_valid  one-cycle completion pulse
//   busy        request cannot be accepted this cycle
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int AW  = 9,
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        data_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
    localparam bit         DIRECT = (LAT == 1);

    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("data_mem_responder: LAT=%0d is outside 1..15", LAT);
    end
    if (AW < 1 || AW > 15) begin : g_bad_aw
        $error("data_mem_responder: AW=%0d is outside 1..15", AW);
    end

    state_t          state;
    logic [3:0]      cnt;
    logic            req_wr;
    logic [AW-1:0]   req_idx;
    logic [15:0]     req_wdata;
    logic [15:0]     mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            c_wr;
    logic [AW-1:0]   c_idx;
    logic [15:0]     c_wdata;

    // Byte-select bit and bits above the word index are deliberately dropped,
    // which is what makes the index wrap modulo 2**AW.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[15:AW+1], addr[0]};

    // With LAT=1 the access commits on the accept edge itself, so it must use
    // the live request; otherwise it uses the request captured at accept.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        accept  = mem_en && !busy;
        commit  = DIRECT ? accept : ((state == WAIT) && (cnt == 4'd1));
        c_wr    = DIRECT ? mem_wr        : req_wr;
        c_idx   = DIRECT ? addr[AW:1]    : req_idx;
        c_wdata = DIRECT ? wdata         : req_wdata;
    end

    // NOTE: the array is deliberately left without a reset; only control state is reset.
    // The rst_n term keeps a LAT=1 store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (commit && c_wr && rst_n) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // NOTE: all state here is assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            rdata      <= 16'h0000;
            req_wr     <= 1'b0;
            req_idx    <= '0;
            req_wdata  <= 16'h0000;
        end else begin
            // A store echoes its data; a load reads the array before this
            // edge's (nonexistent) write, so no bypass is needed.
            if (commit) begin
                rdata <= c_wr ? c_wdata : mem[c_idx];
            end

            case (state)
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        busy       <= 1'b0;
                        data_valid <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept; accepting in RESP gives
                    // back-to-back requests with no idle gap.
                    if (accept) begin
                        req_wr    <= mem_wr;
                        req_idx   <= addr[AW:1];
                        req_wdata <= wdata;
                        if (DIRECT) begin
                            state      <= RESP;
                            busy       <= 1'b0;
                            data_valid <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            cnt        <= LAT_M1;
                            busy       <= 1'b1;
                            data_valid <= 1'b0;
                        end
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        data_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
